// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding scoreboard.
// Entry fields are sized for the largest configuration this block is meant to
// cover (8-bit register addresses, up to 15 forwarding stages). Instances zero-extend
// their narrower fields into these.
package fwd_pkg;

  localparam int RD_W  = 8;
  localparam int RDY_W = 4;

  // Select value meaning "take the operand from the register file".
  localparam int SEL_REGFILE = 0;

  typedef struct packed {
    logic             valid;
    logic [RD_W-1:0]  rd;
    logic [RDY_W-1:0] rdy;
  } entry_t;

  // A ready stage of 0 behaves like 1. Anything past the last stage is pulled back to the last stage.
  function automatic logic [RDY_W-1:0] clamp_rdy(input logic [RDY_W-1:0] rdy,
                                                 input logic [RDY_W-1:0] last_stage);
    logic [RDY_W-1:0] r;
    r = rdy;
    if (r == '0)
      r = RDY_W'(1);
    if (r > last_stage)
      r = last_stage;
    return r;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority search for the youngest in-flight writer of one source register.
// Reports whether one was found, its position, and whether its result
// would still be unforwardable when the consumer reaches EX.
module fwd_match
  import fwd_pkg::*;
#(
  parameter  int NUM_STAGES = 2,
  parameter  int REG_AW     = 5,
  localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic [REG_AW-1:0]           i_src,
  input  logic                        i_used,
  input  entry_t [NUM_STAGES-1:0]     i_entries,
  output logic                        o_hit,
  output logic [SEL_W-1:0]            o_pos,
  output logic                        o_not_ready
);

  logic [RDY_W-1:0] w_rdy;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    o_hit       = 1'b0;
    o_pos       = '0;
    w_rdy       = '0;
    o_not_ready = 1'b0;
    if (i_used && (i_src != '0)) begin
      for (int p = NUM_STAGES - 1; p >= 0; p--) begin
        if (i_entries[p].valid && (i_entries[p].rd == RD_W'(i_src))) begin
          o_hit = 1'b1;
          o_pos = SEL_W'(p);
          w_rdy = i_entries[p].rdy;
        end
      end
    end
    // At position p the consumer would meet the producer at stage p+1.
    o_not_ready = o_hit && ((RDY_W'(o_pos) + RDY_W'(1)) < w_rdy);
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard scoreboard. It sits beside the ID/EX register.
// A shift register of writer tags follows each instruction from EX to WB.
// ID is stalled while a needed result cannot yet be forwarded. Otherwise the
// forward selects are registered so they line up with the consumer in EX.
// Only positions 0..NUM_STAGES-1 are stored. An entry in WB retires before any
// consumer can reach EX, and the write-first register file supplies that value.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int NUM_STAGES = 2,
  parameter  int REG_AW     = 5,
  parameter  int CNT_W      = 32,
  localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hold,
  input  logic              i_flush,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic              i_id_rs1_used,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_reg_write,
  input  logic [SEL_W-1:0]  i_id_rdy_stage,
  output logic              o_stall,
  output logic [SEL_W-1:0]  o_fwd_a,
  output logic [SEL_W-1:0]  o_fwd_b,
  output logic [CNT_W-1:0]  o_stall_count
);

  entry_t [NUM_STAGES-1:0] r_entries;
  logic [SEL_W-1:0]        r_fwd_a;
  logic [SEL_W-1:0]        r_fwd_b;
  logic [CNT_W-1:0]        r_stall_count;

  entry_t                  w_new;
  logic                    w_hit_a;
  logic                    w_hit_b;
  logic [SEL_W-1:0]        w_pos_a;
  logic [SEL_W-1:0]        w_pos_b;
  logic                    w_nr_a;
  logic                    w_nr_b;
  logic                    w_hazard;
  logic                    w_stall;
  logic                    w_advance;

  fwd_match #(
    .NUM_STAGES (NUM_STAGES),
    .REG_AW     (REG_AW)
  ) u_match_a (
    .i_src       (i_id_rs1),
    .i_used      (i_id_rs1_used),
    .i_entries   (r_entries),
    .o_hit       (w_hit_a),
    .o_pos       (w_pos_a),
    .o_not_ready (w_nr_a)
  );

  fwd_match #(
    .NUM_STAGES (NUM_STAGES),
    .REG_AW     (REG_AW)
  ) u_match_b (
    .i_src       (i_id_rs2),
    .i_used      (i_id_rs2_used),
    .i_entries   (r_entries),
    .o_hit       (w_hit_b),
    .o_pos       (w_pos_b),
    .o_not_ready (w_nr_b)
  );

  // Build the tag the ID instruction would carry into EX. Writes to x0 are not tracked.
  always_comb begin
    w_new       = '0;
    w_new.valid = i_id_valid & i_id_reg_write & (i_id_rd != '0);
    w_new.rd    = RD_W'(i_id_rd);
    w_new.rdy   = clamp_rdy(RDY_W'(i_id_rdy_stage), RDY_W'(NUM_STAGES));
  end

  // Hazard detection. A flush kills the instruction, so it removes the need to stall.
  always_comb begin
    w_hazard  = i_id_valid & (w_nr_a | w_nr_b);
    w_stall   = w_hazard & ~i_flush;
    w_advance = i_id_valid & ~w_hazard & ~i_flush;
  end

  // Advance the tag pipeline. A bubble enters EX when ID does not advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_entries <= '0;
    end else if (!i_hold) begin
      for (int k = NUM_STAGES - 1; k > 0; k--)
        r_entries[k] <= r_entries[k-1];
      r_entries[0] <= w_advance ? w_new : entry_t'('0);
    end
  end

  // Register the forward selects so they line up with the consumer once it is in EX.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fwd_a <= SEL_W'(SEL_REGFILE);
      r_fwd_b <= SEL_W'(SEL_REGFILE);
    end else if (!i_hold) begin
      r_fwd_a <= (w_advance && w_hit_a) ? (w_pos_a + SEL_W'(1)) : SEL_W'(SEL_REGFILE);
      r_fwd_b <= (w_advance && w_hit_b) ? (w_pos_b + SEL_W'(1)) : SEL_W'(SEL_REGFILE);
    end
  end

  // Saturating count of cycles lost to hazard stalls. Frozen cycles are not counted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && !i_hold && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign o_stall       = w_stall;
  assign o_fwd_a       = r_fwd_a;
  assign o_fwd_b       = r_fwd_b;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard (NUM_STAGES=2).
// Each driven cycle pushes the forward selects expected in EX after the next edge.
// They are popped and compared one cycle later.
module tb_fwd_scoreboard;

  localparam int NS    = 2;
  localparam int AW    = 5;
  localparam int CW    = 32;
  localparam int SW    = $clog2(NS + 1);

  logic          clk;
  logic          rst_n;
  logic          hold;
  logic          flush;
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic          id_rs1_used;
  logic [AW-1:0] id_rs2;
  logic          id_rs2_used;
  logic [AW-1:0] id_rd;
  logic          id_reg_write;
  logic [SW-1:0] id_rdy_stage;
  logic          stall;
  logic [SW-1:0] fwd_a;
  logic [SW-1:0] fwd_b;
  logic [CW-1:0] stall_count;

  typedef struct {
    string         tag;
    logic [SW-1:0] a;
    logic [SW-1:0] b;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  fwd_scoreboard #(
    .NUM_STAGES (NS),
    .REG_AW     (AW),
    .CNT_W      (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_hold         (hold),
    .i_flush        (flush),
    .i_id_valid     (id_valid),
    .i_id_rs1       (id_rs1),
    .i_id_rs1_used  (id_rs1_used),
    .i_id_rs2       (id_rs2),
    .i_id_rs2_used  (id_rs2_used),
    .i_id_rd        (id_rd),
    .i_id_reg_write (id_reg_write),
    .i_id_rdy_stage (id_rdy_stage),
    .o_stall        (stall),
    .o_fwd_a        (fwd_a),
    .o_fwd_b        (fwd_b),
    .o_stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One ID cycle. First compare EX against the previous cycle's expectation.
  // Then drive ID, check the combinational stall, and queue the EX expectation.
  task automatic drv(input string tag,
                     input logic v, input logic [AW-1:0] rs1, input logic u1,
                     input logic [AW-1:0] rs2, input logic u2,
                     input logic [AW-1:0] rd, input logic rw, input logic [SW-1:0] rdy,
                     input logic hd, input logic fl,
                     input logic exp_stall, input logic [SW-1:0] ea, input logic [SW-1:0] eb);
    exp_t e;
    @(negedge clk);
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      check({e.tag, ".fwd_a"}, 32'(fwd_a), 32'(e.a));
      check({e.tag, ".fwd_b"}, 32'(fwd_b), 32'(e.b));
    end
    id_valid     = v;
    id_rs1       = rs1;
    id_rs1_used  = u1;
    id_rs2       = rs2;
    id_rs2_used  = u2;
    id_rd        = rd;
    id_reg_write = rw;
    id_rdy_stage = rdy;
    hold         = hd;
    flush        = fl;
    #1;
    check({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    e.tag = tag;
    e.a   = ea;
    e.b   = eb;
    q_exp.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drv("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    hold = 0; flush = 0; id_valid = 0; id_rs1 = 0; id_rs1_used = 0;
    id_rs2 = 0; id_rs2_used = 0; id_rd = 0; id_reg_write = 0; id_rdy_stage = 0;
    #2;
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.fwd_a", 32'(fwd_a), 32'd0);
    check("rst.fwd_b", 32'(fwd_b), 32'd0);
    check("rst.count", stall_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU producer, then an immediate consumer gets stage 1 forwarding
    drv("alu_prod", 1, 1, 1, 2, 1, 5, 1, 1, 0, 0, 0, 0, 0);
    drv("alu_use",  1, 5, 1, 1, 1, 6, 1, 1, 0, 0, 0, 1, 0);
    idle(3);

    // load-use: one stall cycle, then forward from stage 2
    drv("lw_prod",  1, 2, 1, 0, 0, 5, 1, 2, 0, 0, 0, 0, 0);
    drv("lw_use0",  1, 5, 1, 5, 1, 7, 1, 1, 0, 0, 1, 0, 0);
    drv("lw_use1",  1, 5, 1, 5, 1, 7, 1, 1, 0, 0, 0, 2, 2);
    check("lw.count", stall_count, 32'd1);
    idle(3);

    // two writers of x5 in flight; youngest wins. x0 source is never forwarded.
    drv("wr5_old",  1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
    drv("wr5_new",  1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
    drv("young",    1, 5, 1, 0, 1, 9, 1, 1, 0, 0, 0, 1, 0);
    idle(3);

    // non-tracked producers: rd=0, and reg_write=0
    drv("rd0_prod", 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    drv("rd0_use",  1, 0, 1, 0, 1, 3, 1, 1, 0, 0, 0, 0, 0);
    drv("nw_prod",  1, 0, 0, 0, 0, 8, 0, 2, 0, 0, 0, 0, 0);
    drv("nw_use",   1, 8, 1, 8, 1, 4, 1, 1, 0, 0, 0, 0, 0);
    idle(3);

    // hazard under hold: state frozen, stall still driven
    drv("x10_prod", 1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0);
    drv("lw9",      1, 10, 1, 0, 0, 9, 1, 2, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      drv("hold",   1, 9, 1, 0, 0, 14, 1, 1, 1, 0, 1, 1, 0);
    check("hold.count", stall_count, 32'd1);
    drv("unhold0",  1, 9, 1, 0, 0, 14, 1, 1, 0, 0, 1, 0, 0);
    drv("unhold1",  1, 9, 1, 0, 0, 14, 1, 1, 0, 0, 0, 2, 0);
    check("unhold.count", stall_count, 32'd2);
    idle(3);

    // flush beats hazard: bubble, no stall, no count
    drv("lw11",     1, 0, 0, 0, 0, 11, 1, 2, 0, 0, 0, 0, 0);
    drv("flush",    1, 11, 1, 0, 0, 15, 1, 1, 0, 1, 0, 0, 0);
    drv("post_fl",  1, 11, 1, 0, 0, 15, 1, 1, 0, 0, 0, 2, 0);
    check("flush.count", stall_count, 32'd2);
    idle(3);

    // asynchronous reset in the middle of a stall
    drv("x13_prod", 1, 0, 0, 0, 0, 13, 1, 1, 0, 0, 0, 0, 0);
    drv("lw12",     1, 13, 1, 0, 0, 12, 1, 2, 0, 0, 0, 1, 0);
    drv("rst_use",  1, 12, 1, 0, 0, 16, 1, 1, 0, 0, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst.stall", 32'(stall), 32'd0);
    check("midrst.fwd_a", 32'(fwd_a), 32'd0);
    check("midrst.fwd_b", 32'(fwd_b), 32'd0);
    check("midrst.count", stall_count, 32'd0);
    rst_n = 1'b1;
    #1;
    check("postrst.stall", 32'(stall), 32'd0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the two-stage combinational forwarding unit; combines forwarding and load-use hazard detection.
- Tracks in-flight register writers across NUM_STAGES post-EX pipeline stages in an internal tag shift register.
- Each writer carries a per-instruction "result ready" stage. Asserts an ID stall when a consumer would reach EX before its producer's result is forwardable.
- Otherwise produces registered forward selects aligned to the instruction in EX. Sits beside the ID/EX pipeline register.

Parameters:
- NUM_STAGES, 2, post-EX stages that can forward; stage 1 = EX/MEM, stage NUM_STAGES = WB.
- REG_AW, 5, register address width; register 0 is hardwired zero.
- CNT_W, 32, stall counter width.
- SEL_W, $clog2(NUM_STAGES+1), derived local; width of select and ready-stage fields.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  global pipeline freeze (e.g. memory wait); block state is frozen
- flush  in  1  kill the ID instruction instead of advancing it into EX
- id_valid  in  1  ID holds a valid instruction
- id_rs1  in  REG_AW  source A address
- id_rs1_used  in  1  source A is read
- id_rs2  in  REG_AW  source B address
- id_rs2_used  in  1  source B is read
- id_rd  in  REG_AW  destination
- id_reg_write  in  1  instruction writes rd
- id_rdy_stage  in  SEL_W  first stage (1..NUM_STAGES) whose output holds the result; ALU=1, load=2
- stall  out  1  combinational; ID/IF must hold this cycle
- fwd_a  out  SEL_W  registered select for EX operand A; 0 = register file, k = stage k output
- fwd_b  out  SEL_W  as fwd_a for operand B
- stall_count  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Entry fields: valid, rd, rdy.
  - Positions 0..NUM_STAGES: position 0 = instruction now in EX; position k = stage k.
  - Entries leaving position NUM_STAGES retire. The register file must be write-first so ID reads see WB writes.
- Entry captured from ID: valid = id_valid & id_reg_write & (id_rd != 0).
  - rdy: 0 is treated as 1; values above NUM_STAGES are clamped to NUM_STAGES.
- Match for source s, evaluated only when its used bit is set and s != 0:
  - Find the youngest (lowest p, 0..NUM_STAGES-1) valid entry with rd == s.
  - Entry at position NUM_STAGES is ignored; it retires before the consumer is in EX.
  - Youngest match wins even if older matches are ready; an older stale value is never forwarded.
- Hazard (combinational): id_valid & some used source's youngest match has p+1 < rdy. stall = hazard & !flush.
- Sequential update, rising clk, only when hold=0:
  - Positions shift: pos[k+1] <= pos[k].
  - pos[0] <= ID entry if id_valid & !stall & !flush; otherwise an invalid bubble.
  - fwd_a/fwd_b <= (p+1) of the youngest match when the ID instruction advances; otherwise 0.
- hold=1: all entries, fwd_a, fwd_b and stall_count are unchanged. The stall output is still driven.
- flush and hazard in the same cycle: flush wins; a bubble is inserted and stall is low.
- stall_count increments when stall & !hold and saturates at all ones.
- Reset (asynchronous, rst_n=0): all entries invalid; fwd_a = fwd_b = 0; stall_count = 0. Reset mid-stall drops all tracking, so stall deasserts immediately.
- Latency: selects valid 1 cycle after the consumer leaves ID, i.e. coincident with it in EX. stall has 0 latency.

Decomposition:
- Package fwd_pkg:
  - entry typedef (valid, rd, rdy);
  - SEL_REGFILE = 0 constant;
  - function clamping rdy.
- Sub-module fwd_match, instantiated twice (A and B):
  - inputs: source address, used bit, entry array;
  - outputs: hit, position, not-ready flag;
  - implemented as a parametrised priority search.

Test Plan:
- NUM_STAGES=2: add x5 (rdy=1), then next cycle add x6=x5+x1 -> stall=0; in EX fwd_a=1, fwd_b=0.
- lw x5 (rdy=2), then next cycle use x5 -> stall=1 for one cycle, stall_count=1; consumer then enters EX with fwd_a=2.
- Writes to x5 at positions 0 and 1, then a consumer of x5 -> fwd selects youngest (fwd_a=1), never 2.
- id_rd=0 or id_reg_write=0 producer, followed by a consumer of the same register -> no stall, fwd_a=fwd_b=0.
- Hazard present with hold=1 for 3 cycles -> entries, fwd_a/fwd_b and stall_count frozen; stall stays 1. After hold drops, normal progress resumes.
- Hazard and flush in the same cycle -> stall=0, bubble enters EX (fwd_a=0). rst_n pulsed low mid-sequence -> all outputs 0 asynchronously.
